// File: rtl/serpent_de_core.sv
// Serpent block decryption core with one round per clock and external subkey fetch via o_key_idx.
// Result appears 33 cycles after acceptance. It is held in DONE until i_ready. No overlap between blocks.
module serpent_de_core (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  output logic [5:0]   o_key_idx,
  input  logic [127:0] i_subkey,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data
);

  typedef enum logic [2:0] {IDLE, KEY32, FINAL, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] blk;
  logic [4:0]   rnd;
  logic [127:0] lt_out;
  logic [127:0] sb_in;
  logic [127:0] sb_out;
  logic [2:0]   sb_sel;

  // Nibble j of each constant holds InvS[k][j].
  function automatic logic [3:0] inv_sbox_nib(input logic [2:0] k, input logic [3:0] n);
    logic [63:0] tbl;
    case (k)
      3'd0:    tbl = 64'h289F_74E1_C56A_0B3D;
      3'd1:    tbl = 64'h0AD1_974B_3C6F_E285;
      3'd2:    tbl = 64'h7A85_D630_21EB_4F9C;
      3'd3:    tbl = 64'h1F84_2C53_D6EB_7A90;
      3'd4:    tbl = 64'h1DF4_6BC2_E79A_3805;
      3'd5:    tbl = 64'h0AC7_356B_ED14_92F8;
      3'd6:    tbl = 64'hB8C2_7E94_0635_D1AF;
      default: tbl = 64'h241A_7BC5_8FE9_D603;
    endcase
    return tbl[{n, 2'b00} +: 4];
  endfunction

  // Column i is the nibble {X3[i],X2[i],X1[i],X0[i]} with X0 as LSB.
  function automatic logic [127:0] inv_sbox_slice(input logic [2:0] k, input logic [127:0] x);
    logic [127:0] y;
    logic [3:0]   n;
    logic [3:0]   o;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      n = {x[96+i], x[64+i], x[32+i], x[i]};
      o = inv_sbox_nib(k, n);
      y[i]    = o[0];
      y[32+i] = o[1];
      y[64+i] = o[2];
      y[96+i] = o[3];
    end
    return y;
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] s);
    return (v >> s) | (v << (6'd32 - {1'b0, s}));
  endfunction

  function automatic logic [127:0] inv_lt(input logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = x;
    x2 = ror32(x2, 5'd22) ^ x3 ^ (x1 << 7);
    x0 = ror32(x0, 5'd5) ^ x1 ^ x3;
    x3 = ror32(x3, 5'd7) ^ x2 ^ (x0 << 3);
    x1 = ror32(x1, 5'd1) ^ x0 ^ x2;
    x2 = ror32(x2, 5'd3);
    x0 = ror32(x0, 5'd13);
    return {x3, x2, x1, x0};
  endfunction

  // FINAL undoes the last encryption round, which has no linear transform.
  assign lt_out = inv_lt(blk);
  assign sb_sel = (fsm == FINAL) ? 3'd7 : rnd[2:0];
  assign sb_in  = (fsm == FINAL) ? blk : lt_out;
  assign sb_out = inv_sbox_slice(sb_sel, sb_in) ^ i_subkey;
  assign o_data = blk;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm       <= IDLE;
      blk       <= '0;
      rnd       <= '0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_key_idx <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (i_valid) begin
            blk       <= i_data;
            fsm       <= KEY32;
            o_ready   <= 1'b0;
            o_key_idx <= 6'd32;
          end
        end
        KEY32: begin
          blk       <= blk ^ i_subkey;
          fsm       <= FINAL;
          o_key_idx <= 6'd31;
        end
        FINAL: begin
          blk       <= sb_out;
          rnd       <= 5'd30;
          fsm       <= ROUND;
          o_key_idx <= 6'd30;
        end
        ROUND: begin
          blk <= sb_out;
          if (rnd == 5'd0) begin
            fsm       <= DONE;
            o_valid   <= 1'b1;
            o_key_idx <= 6'd0;
          end else begin
            rnd       <= rnd - 5'd1;
            o_key_idx <= {1'b0, rnd - 5'd1};
          end
        end
        DONE: begin
          if (i_ready) begin
            fsm     <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          fsm       <= IDLE;
          o_ready   <= 1'b1;
          o_valid   <= 1'b0;
          o_key_idx <= '0;
        end
      endcase
    end
  end

endmodule
